// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared operation/state encodings and default width for muldiv_unit
package muldiv_pkg;
  localparam int MULDIV_WIDTH = 32;
  typedef enum logic [1:0] {OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: execute-stage start/done and MTHI/MTLO bundle for muldiv_unit
interface muldiv_if #(parameter int WIDTH = muldiv_pkg::MULDIV_WIDTH);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic cancel;
  logic hi_we;
  logic lo_we;
  logic [WIDTH-1:0] wdata;
  logic busy;
  logic done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, op, srca, srcb, cancel, hi_we, lo_we, wdata, input busy, done, hi, lo);
  modport slave(input start, op, srca, srcb, cancel, hi_we, lo_we, wdata, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply / restoring divide sharing one adder, with HI/LO state
module muldiv_unit import muldiv_pkg::*; #(parameter int WIDTH = MULDIV_WIDTH) (
  input logic clk,
  input logic rst,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic div_q, div_d, neg_q, neg_d, dneg_q, dneg_d, dz_q, dz_d, done_q, done_d;
  logic [WIDTH-1:0] b_q, b_d, acc_q, acc_d, sh_q, sh_d, hi_q, hi_d, lo_q, lo_d;
  logic sgn, a_neg, b_neg;
  logic [WIDTH:0] x, y;
  logic [WIDTH+1:0] sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;
  always_comb begin
    sgn = bus.op inside {OP_MULT, OP_DIV};
    a_neg = sgn & bus.srca[WIDTH-1];
    b_neg = sgn & bus.srcb[WIDTH-1];
    x = div_q ? {acc_q, sh_q[WIDTH-1]} : {1'b0, acc_q};
    y = div_q ? ~{1'b0, b_q} : (sh_q[0] ? {1'b0, b_q} : '0);
    sum = {1'b0, x} + {1'b0, y} + (WIDTH+2)'(div_q);
    prod = neg_q ? -{acc_q, sh_q} : {acc_q, sh_q};
    quo = dz_q ? '1 : neg_q ? -sh_q : sh_q;
    rem = dneg_q ? -acc_q : acc_q;
    state_d = state_q;
    cnt_d = cnt_q;
    div_d = div_q;
    neg_d = neg_q;
    dneg_d = dneg_q;
    dz_d = dz_q;
    b_d = b_q;
    acc_d = acc_q;
    sh_d = sh_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      hi_d = bus.hi_we ? bus.wdata : hi_q;
      lo_d = bus.lo_we ? bus.wdata : lo_q;
      if (bus.start && !bus.cancel) begin
        state_d = RUN;
        cnt_d = CW'(WIDTH-1);
        div_d = bus.op inside {OP_DIVU, OP_DIV};
        neg_d = a_neg ^ b_neg;
        dneg_d = a_neg;
        dz_d = (bus.op inside {OP_DIVU, OP_DIV}) && bus.srcb == '0;
        b_d = b_neg ? -bus.srcb : bus.srcb;
        acc_d = '0;
        sh_d = a_neg ? -bus.srca : bus.srca;
      end
    end else if (bus.cancel) begin
      state_d = IDLE;
    end else if (state_q == RUN) begin
      acc_d = !div_q ? sum[WIDTH:1] : sum[WIDTH+1] ? sum[WIDTH-1:0] : x[WIDTH-1:0];
      sh_d = div_q ? {sh_q[WIDTH-2:0], sum[WIDTH+1]} : {sum[0], sh_q[WIDTH-1:1]};
      state_d = cnt_q == '0 ? FIN : RUN;
      cnt_d = cnt_q - CW'(1);
    end else begin
      state_d = IDLE;
      done_d = 1'b1;
      hi_d = div_q ? rem : prod[2*WIDTH-1:WIDTH];
      lo_d = div_q ? quo : prod[WIDTH-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      dneg_q <= 1'b0;
      dz_q <= 1'b0;
      done_q <= 1'b0;
      b_q <= '0;
      acc_q <= '0;
      sh_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      neg_q <= neg_d;
      dneg_q <= dneg_d;
      dz_q <= dz_d;
      done_q <= done_d;
      b_q <= b_d;
      acc_q <= acc_d;
      sh_q <= sh_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboarded random and directed checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
  import muldiv_pkg::*;
  typedef struct {logic [63:0] res; int at;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int ecount = 0;
  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];
  muldiv_if #(.WIDTH(32)) bus();
  muldiv_unit #(.WIDTH(32)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;
  function automatic logic [63:0] model(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    longint sa, sb2, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb2 = longint'($signed(b));
    if (o == OP_MULTU) res = {32'h0, a} * {32'h0, b};
    else if (o == OP_MULT) res = sa * sb2;
    else if (b == 0) res = {a, 32'hFFFF_FFFF};
    else if (o == OP_DIVU) res = {a % b, a / b};
    else begin
      q = sa / sb2;
      r = sa % sb2;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic issue(logic [1:0] o, logic [31:0] a, logic [31:0] b, bit push);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = o;
    bus.srca = a;
    bus.srcb = b;
    if (push) sb.push_back('{model(o, a, b), ecount + 34});
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_idle();
    int k = 0;
    while ((sb.size() != 0 || bus.busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: timeout with %0d results pending", sb.size());
    end
  endtask
  function automatic logic [31:0] pick();
    logic [31:0] c[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    return ($urandom_range(3) == 0) ? c[$urandom_range(4)] : $urandom;
  endfunction
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with nothing pending", ecount);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({bus.hi, bus.lo} !== e.res || ecount != e.at) begin
          n_err++;
          $display("FAIL result: got hi/lo %h/%h at cycle %0d, expected %h/%h at cycle %0d",
                   bus.hi, bus.lo, ecount, e.res[63:32], e.res[31:0], e.at);
        end
      end
    end
  end
  initial begin
    logic [63:0] held_first, held_last;
    int bad, next_free, n_acc;
    logic [1:0] o;
    logic [31:0] a, b;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.srca = '0;
    bus.srcb = '0;
    bus.cancel = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);
    check("reset_busy", {31'h0, bus.busy}, 32'h0);
    check("reset_done", {31'h0, bus.done}, 32'h0);
    rst = 1'b0;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    bad = 0;
    for (int i = 1; i <= 33; i++) begin
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
      if (i < 33) @(negedge clk);
    end
    check("busy_window_1_33", bad, 0);
    @(negedge clk);
    check("busy_in_done_cycle", {31'h0, bus.busy}, 32'h0);
    check("done_cycle_34", {31'h0, bus.done}, 32'h1);
    check("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_max_lo", bus.lo, 32'h0000_0001);
    wait_idle();
    issue(OP_MULT, 32'hFFFF_FFFD, 32'h5, 1'b1);
    wait_idle();
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_idle();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b1);
    wait_idle();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'h0);
    issue(OP_DIVU, 32'h64, 32'h0, 1'b1);
    wait_idle();
    check("divu_zero_lo", bus.lo, 32'hFFFF_FFFF);
    check("divu_zero_hi", bus.hi, 32'h64);
    @(negedge clk);
    check("done_single_pulse", {31'h0, bus.done}, 32'h0);
    issue(OP_DIV, 32'hFFFF_FF00, 32'h0, 1'b1);
    wait_idle();
    bus.hi_we = 1'b1;
    bus.wdata = 32'h11;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h22;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mthi_preload", bus.hi, 32'h11);
    check("mtlo_preload", bus.lo, 32'h22);
    issue(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (9) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_busy_cycle11", {31'h0, bus.busy}, 32'h0);
    repeat (40) @(negedge clk);
    check("cancel_hi_kept", bus.hi, 32'h11);
    check("cancel_lo_kept", bus.lo, 32'h22);
    bus.start = 1'b1;
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    check("start_cancel_idle", {31'h0, bus.busy}, 32'h0);
    repeat (36) @(negedge clk);
    check("start_cancel_no_done_hi", bus.hi, 32'h11);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hA5A5_5A5A;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("mthi_mtlo_both_hi", bus.hi, 32'hA5A5_5A5A);
    check("mthi_mtlo_both_lo", bus.lo, 32'hA5A5_5A5A);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_DIVU;
    bus.srca = 32'd1000;
    bus.srcb = 32'd7;
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0BAD_F00D;
    sb.push_back('{model(OP_DIVU, 32'd1000, 32'd7), ecount + 34});
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    check("mthi_with_start", bus.hi, 32'h0BAD_F00D);
    wait_idle();
    next_free = 0;
    n_acc = 0;
    held_first = '0;
    held_last = '0;
    for (int c = 0; c < 102; c++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = 2'($urandom_range(3));
      bus.srca = pick();
      bus.srcb = pick();
      if (ecount >= next_free) begin
        held_last = model(bus.op, bus.srca, bus.srcb);
        if (n_acc == 0) held_first = held_last;
        sb.push_back('{held_last, ecount + 34});
        next_free = ecount + 34;
        n_acc++;
      end
      bus.hi_we = (c == 50);
      bus.wdata = 32'hDEAD_BEEF;
      if (c == 51) check("mthi_dropped_while_busy", bus.hi, held_first[63:32]);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b1;
    bus.wdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("mthi_in_done_cycle", bus.hi, 32'hCAFE_F00D);
    check("lo_after_done_mthi", bus.lo, held_last[31:0]);
    check("held_start_accepts", n_acc, 3);
    wait_idle();
    for (int t = 0; t < 40; t++) begin
      o = 2'($urandom_range(3));
      a = pick();
      b = ($urandom_range(7) == 0) ? 32'h0 : pick();
      issue(o, a, b, 1'b1);
      wait_idle();
    end
    repeat (40) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
